// File: rtl/matmul_seq_mac_pkg.sv
// Shared definitions for the sequential matrix multiplier.
//   state_t    : controller states (IDLE / COMPUTE / DONE)
//   clog2      : constant ceil(log2(v)), with clog2(1) = 0
//   acc_width  : accumulator / result element width, 2*W + clog2(N)
//   idx_width  : width of the i/j/k loop indices (at least 1 bit)
package matmul_seq_mac_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Sum of N products of two W-bit values needs 2W bits plus clog2(N)
  // bits of growth, so the accumulator can never overflow.
  function automatic int acc_width(input int w, input int n);
    return 2 * w + clog2(n);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matmul_mac_unit.sv
// Combinational multiply-accumulate: acc_out = acc_in + ext(x * y).
//   x, y    : W-bit operands (signed or unsigned per SIGNED)
//   acc_in  : AW-bit running sum
//   acc_out : AW-bit updated sum
// The W x W product is formed at full 2W precision and then sign- or
// zero-extended to AW before the add.
module matmul_mac_unit #(
  parameter int W      = 8,
  parameter int AW     = 17,
  parameter int SIGNED = 0
) (
  input  logic [W-1:0]  x,
  input  logic [W-1:0]  y,
  input  logic [AW-1:0] acc_in,
  output logic [AW-1:0] acc_out
);

  logic [2*W-1:0] prod;
  logic [AW-1:0]  prod_ext;

  if (SIGNED != 0) begin : g_signed
    // Extending both operands to 2W makes the low 2W bits of the product
    // the exact two's-complement result.
    assign prod     = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
    assign prod_ext = AW'($signed(prod));
  end else begin : g_unsigned
    assign prod     = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    assign prod_ext = AW'(prod);
  end

  assign acc_out = acc_in + prod_ext;

endmodule

// File: rtl/matmul_seq_mac.sv
// Sequential N x N matrix multiplier, C = A x B, built around one shared
// MAC unit. One MAC per cycle, N^3 cycles per matrix.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake for a and b
//   a, b                : row-major W-bit matrices, element (0,0) in LSBs
//   out_valid/out_ready : result handshake for c
//   c                   : row-major AW-bit result matrix
//   busy                : high while the MAC loop is running
module matmul_seq_mac
  import matmul_seq_mac_pkg::*;
#(
  parameter  int N      = 2,
  parameter  int W      = 8,
  parameter  int SIGNED = 0,
  localparam int AW     = acc_width(W, N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*N*W-1:0]  a,
  input  logic [N*N*W-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*N*AW-1:0] c,
  output logic              busy
);

  localparam int            IW   = idx_width(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t            state, state_next;
  logic [N*N*W-1:0]  a_reg, b_reg;
  logic [N*N*AW-1:0] c_reg;
  logic [AW-1:0]     acc, acc_next;
  logic [IW-1:0]     i, j, k;
  logic [W-1:0]      a_el, b_el;
  logic              accept, k_last, j_last, i_last;

  assign accept = in_valid && (state == IDLE);
  assign k_last = (k == LAST);
  assign j_last = (j == LAST);
  assign i_last = (i == LAST);

  assign a_el = a_reg[(int'(i) * N + int'(k)) * W +: W];
  assign b_el = b_reg[(int'(k) * N + int'(j)) * W +: W];

  matmul_mac_unit #(.W(W), .AW(AW), .SIGNED(SIGNED)) u_mac (
    .x       (a_el),
    .y       (b_el),
    .acc_in  (acc),
    .acc_out (acc_next)
  );

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)                   state_next = COMPUTE;
      COMPUTE: if (k_last && j_last && i_last) state_next = DONE;
      DONE:    if (out_ready)                  state_next = IDLE;
      default:                                 state_next = IDLE;
    endcase
  end

  // Moore outputs, decoded from the current state only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      COMPUTE: busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Operand capture.
  // NOTE: the operand registers deliberately have no reset: they are only
  // read in COMPUTE, which is always preceded by a capture, so resetting
  // them would add reset fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_reg <= a;
      b_reg <= b;
    end
  end

  // MAC loop: k innermost, then j, then i. The last k step of each (i,j)
  // writes the finished sum into C and restarts the accumulator at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_reg <= '0;
      acc   <= '0;
      i     <= '0;
      j     <= '0;
      k     <= '0;
    end else if (accept) begin
      acc <= '0;
      i   <= '0;
      j   <= '0;
      k   <= '0;
    end else if (state == COMPUTE) begin
      if (k_last) begin
        c_reg[(int'(i) * N + int'(j)) * AW +: AW] <= acc_next;
        acc <= '0;
        k   <= '0;
        if (j_last) begin
          j <= '0;
          i <= i_last ? '0 : i + IW'(1);
        end else begin
          j <= j + IW'(1);
        end
      end else begin
        acc <= acc_next;
        k   <= k + IW'(1);
      end
    end
  end

  assign c = c_reg;

endmodule
